// File: rtl/mac_ip_deadlock_monitor_p.sv
// Dataflow deadlock monitor: flags a deadlock once every process is stopped and at least
// one stop is a genuine block, held for THRESH consecutive cycles; snapshots the cause.
module mac_ip_deadlock_monitor_p #(
  parameter int                           NUM_PROC  = 10,
  parameter int                           NUM_AXIS  = 4,
  parameter logic [NUM_PROC*NUM_AXIS-1:0] AXIS_MAP  = 40'h00_0008_4210,
  parameter int                           THRESH    = 1,
  parameter int                           STICKY    = 0,
  parameter int                           CHAN_MODE = 0,
  parameter int                           CNT_W     = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_PROC-1:0] inst_idle_sigs,
  input  logic [NUM_PROC-1:0] inst_block_sigs,
  input  logic                clear,
  output logic                block,
  output logic                block_pulse,
  output logic [NUM_PROC-1:0] snap_axis,
  output logic [NUM_PROC-1:0] snap_chan,
  output logic [CNT_W-1:0]    event_count
);

  localparam int               CW       = $clog2(THRESH + 1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(THRESH - 1);
  localparam logic [CNT_W-1:0] EVT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_MONITOR   = 2'd0,
    ST_CANDIDATE = 2'd1,
    ST_DEADLOCK  = 2'd2
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [CW-1:0]       cnt_r, cnt_nxt_s;
  logic [NUM_PROC-1:0] pab_s;
  logic                cond_s;
  logic                entry_s;

  // Per-process axis block and the overall deadlock condition
  always_comb begin
    pab_s = {NUM_PROC{1'b0}};
    for (int i = 0; i < NUM_PROC; i++) begin
      for (int j = 0; j < NUM_AXIS; j++) begin
        pab_s[i] = pab_s[i] | (axis_block_sigs[j] & AXIS_MAP[i*NUM_AXIS+j]);
      end
    end
    // all-idle with nothing blocked is a drained region, not a deadlock
    cond_s = (&(inst_idle_sigs | inst_block_sigs | pab_s)) &
             ((|pab_s) | ((CHAN_MODE != 0) & (|inst_block_sigs)));
  end

  // Next-state and stall-counter logic; clear overrides everything
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    entry_s     = 1'b0;
    if (clear) begin
      state_nxt_s = ST_MONITOR;
      cnt_nxt_s   = {CW{1'b0}};
    end else begin
      case (state_r)
        ST_MONITOR: begin
          if (cond_s && (THRESH == 1)) begin
            state_nxt_s = ST_DEADLOCK;
            cnt_nxt_s   = {CW{1'b0}};
            entry_s     = 1'b1;
          end else if (cond_s) begin
            state_nxt_s = ST_CANDIDATE;
            cnt_nxt_s   = CW'(1);
          end else begin
            cnt_nxt_s   = {CW{1'b0}};
          end
        end
        ST_CANDIDATE: begin
          if (!cond_s) begin
            state_nxt_s = ST_MONITOR;
            cnt_nxt_s   = {CW{1'b0}};
          end else if (cnt_r == CNT_LAST) begin
            state_nxt_s = ST_DEADLOCK;
            cnt_nxt_s   = {CW{1'b0}};
            entry_s     = 1'b1;
          end else begin
            cnt_nxt_s   = cnt_r + CW'(1);
          end
        end
        ST_DEADLOCK: begin
          if ((STICKY == 0) && !cond_s) begin
            state_nxt_s = ST_MONITOR;
          end else begin
            state_nxt_s = ST_DEADLOCK;
          end
        end
        default: begin
          state_nxt_s = ST_MONITOR;
          cnt_nxt_s   = {CW{1'b0}};
        end
      endcase
    end
  end

  // State register and registered outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r     <= ST_MONITOR;
      cnt_r       <= {CW{1'b0}};
      block       <= 1'b0;
      block_pulse <= 1'b0;
      snap_axis   <= {NUM_PROC{1'b0}};
      snap_chan   <= {NUM_PROC{1'b0}};
      event_count <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      block       <= (state_nxt_s == ST_DEADLOCK);
      block_pulse <= entry_s;
      if (entry_s) begin
        snap_axis <= pab_s;
        snap_chan <= inst_block_sigs;
        if (event_count != EVT_MAX) begin
          event_count <= event_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_ip_deadlock_monitor_p.sv
// Directed bench for mac_ip_deadlock_monitor_p: vector table on the default build plus
// sequences on THRESH, STICKY, CHAN_MODE and narrow-counter builds.
module tb_mac_ip_deadlock_monitor_p;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] axis;
  logic [9:0] idle;
  logic [9:0] chan;
  logic       clr;

  logic a_block, a_pulse, t_block, t_pulse, s_block, s_pulse, c_block, c_pulse, n_block, n_pulse;
  logic [9:0]  a_sa, a_sc, t_sa, t_sc, s_sa, s_sc, c_sa, c_sc, n_sa, n_sc;
  logic [15:0] a_cnt, t_cnt, s_cnt, c_cnt;
  logic [1:0]  n_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;

  always #5 clock = ~clock;

  mac_ip_deadlock_monitor_p dut_a (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
    .inst_block_sigs(chan), .clear(clr), .block(a_block), .block_pulse(a_pulse),
    .snap_axis(a_sa), .snap_chan(a_sc), .event_count(a_cnt));

  mac_ip_deadlock_monitor_p #(.THRESH(4)) dut_t (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
    .inst_block_sigs(chan), .clear(clr), .block(t_block), .block_pulse(t_pulse),
    .snap_axis(t_sa), .snap_chan(t_sc), .event_count(t_cnt));

  mac_ip_deadlock_monitor_p #(.STICKY(1)) dut_s (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
    .inst_block_sigs(chan), .clear(clr), .block(s_block), .block_pulse(s_pulse),
    .snap_axis(s_sa), .snap_chan(s_sc), .event_count(s_cnt));

  mac_ip_deadlock_monitor_p #(.CHAN_MODE(1)) dut_c (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
    .inst_block_sigs(chan), .clear(clr), .block(c_block), .block_pulse(c_pulse),
    .snap_axis(c_sa), .snap_chan(c_sc), .event_count(c_cnt));

  mac_ip_deadlock_monitor_p #(.CNT_W(2)) dut_n (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
    .inst_block_sigs(chan), .clear(clr), .block(n_block), .block_pulse(n_pulse),
    .snap_axis(n_sa), .snap_chan(n_sc), .event_count(n_cnt));

  typedef struct packed {
    logic        rst;
    logic [9:0]  idle;
    logic [3:0]  axis;
    logic [9:0]  chan;
    logic        clr;
    logic        e_block;
    logic        e_pulse;
    logic [9:0]  e_sa;
    logic [9:0]  e_sc;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Apply one cycle of inputs, then wait past the edge that samples them
  task automatic step(input logic r, input logic [9:0] i, input logic [3:0] a,
                      input logic [9:0] c, input logic cl);
    reset = r; idle = i; axis = a; chan = c; clr = cl;
    @(posedge clock);
    #1;
  endtask

  task automatic q();  step(1'b1, 10'h3FD, 4'h1, 10'h000, 1'b0); endtask
  task automatic nq(); step(1'b1, 10'h3FF, 4'h0, 10'h000, 1'b0); endtask

  initial begin
    reset = 1'b0; idle = 10'h3FF; axis = 4'h0; chan = 10'h000; clr = 1'b0;

    // rst idle axis chan clr | block pulse snap_axis snap_chan count  (default build)
    vecs[0]  = '{1'b0, 10'h3FD, 4'h1, 10'h000, 1'b1, 1'b0, 1'b0, 10'h000, 10'h000, 16'd0};
    vecs[1]  = '{1'b1, 10'h3FF, 4'h0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 16'd0};
    vecs[2]  = '{1'b1, 10'h3FD, 4'h1, 10'h000, 1'b0, 1'b1, 1'b1, 10'h002, 10'h000, 16'd1};
    vecs[3]  = '{1'b1, 10'h3FD, 4'h1, 10'h000, 1'b0, 1'b1, 1'b0, 10'h002, 10'h000, 16'd1};
    vecs[4]  = '{1'b1, 10'h3FF, 4'h0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h002, 10'h000, 16'd1};
    vecs[5]  = '{1'b1, 10'h3FD, 4'h1, 10'h004, 1'b0, 1'b1, 1'b1, 10'h002, 10'h004, 16'd2};
    vecs[6]  = '{1'b1, 10'h3FF, 4'h0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h002, 10'h004, 16'd2};
    vecs[7]  = '{1'b1, 10'h3F9, 4'h1, 10'h000, 1'b0, 1'b0, 1'b0, 10'h002, 10'h004, 16'd2};
    vecs[8]  = '{1'b1, 10'h3F9, 4'h3, 10'h000, 1'b0, 1'b1, 1'b1, 10'h006, 10'h000, 16'd3};
    vecs[9]  = '{1'b1, 10'h3F9, 4'h3, 10'h000, 1'b1, 1'b0, 1'b0, 10'h006, 10'h000, 16'd3};
    vecs[10] = '{1'b1, 10'h3F9, 4'h3, 10'h000, 1'b0, 1'b1, 1'b1, 10'h006, 10'h000, 16'd4};
    vecs[11] = '{1'b1, 10'h3FF, 4'h0, 10'h000, 1'b1, 1'b0, 1'b0, 10'h006, 10'h000, 16'd4};
    vecs[12] = '{1'b1, 10'h3FD, 4'h1, 10'h000, 1'b1, 1'b0, 1'b0, 10'h006, 10'h000, 16'd4};
    vecs[13] = '{1'b1, 10'h3FE, 4'h0, 10'h001, 1'b0, 1'b0, 1'b0, 10'h006, 10'h000, 16'd4};
    vecs[14] = '{1'b1, 10'h3EF, 4'h8, 10'h000, 1'b0, 1'b1, 1'b1, 10'h010, 10'h000, 16'd5};
    vecs[15] = '{1'b0, 10'h3EF, 4'h8, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 16'd0};
    vecs[16] = '{1'b1, 10'h3EF, 4'h8, 10'h000, 1'b0, 1'b1, 1'b1, 10'h010, 10'h000, 16'd1};
    vecs[17] = '{1'b1, 10'h3FE, 4'hF, 10'h000, 1'b0, 1'b0, 1'b0, 10'h010, 10'h000, 16'd1};

    @(negedge clock);
    for (int r = 0; r < 18; r++) begin
      step(vecs[r].rst, vecs[r].idle, vecs[r].axis, vecs[r].chan, vecs[r].clr);
      chk($sformatf("row%0d block", r), 32'(a_block), 32'(vecs[r].e_block));
      chk($sformatf("row%0d pulse", r), 32'(a_pulse), 32'(vecs[r].e_pulse));
      chk($sformatf("row%0d snap_axis", r), 32'(a_sa), 32'(vecs[r].e_sa));
      chk($sformatf("row%0d snap_chan", r), 32'(a_sc), 32'(vecs[r].e_sc));
      chk($sformatf("row%0d count", r), 32'(a_cnt), 32'(vecs[r].e_cnt));
    end

    // Reset state of every build
    step(1'b0, 10'h3FD, 4'h1, 10'h000, 1'b0);
    chk("rst all outputs", {a_block, a_pulse, t_block, t_pulse, s_block, s_pulse,
                            c_block, c_pulse, n_block, n_pulse, n_cnt, 20'h00000}, 32'h0);
    chk("rst snaps a/t", {2'b00, a_sa, a_sc, t_sa[9:0] & 10'h3FF} , 32'h0);
    chk("rst snaps s/c", {2'b00, s_sa, s_sc, c_sa}, 32'h0);
    chk("rst snaps c/n", {2'b00, c_sc, n_sa, n_sc}, 32'h0);
    chk("rst counts", {a_cnt, t_cnt | s_cnt | c_cnt}, 32'h0);
    chk("rst t snap_chan", 32'(t_sc), 32'h0);

    // THRESH=4: 3-cycle burst, gap, then 4-cycle burst
    for (int k = 0; k < 3; k++) begin
      q();
      chk($sformatf("thr burst1 c%0d", k), 32'(t_block), 32'h0);
    end
    nq();
    chk("thr gap", 32'(t_block), 32'h0);
    for (int k = 0; k < 3; k++) begin
      q();
      chk($sformatf("thr burst2 c%0d", k), 32'(t_block), 32'h0);
    end
    q();
    chk("thr rise block", 32'(t_block), 32'h1);
    chk("thr rise pulse", 32'(t_pulse), 32'h1);
    chk("thr count", 32'(t_cnt), 32'd1);
    q();
    chk("thr hold block", 32'(t_block), 32'h1);
    chk("thr hold pulse", 32'(t_pulse), 32'h0);

    // THRESH=4: reset mid-candidate discards progress
    nq();
    q(); q();
    step(1'b0, 10'h3FD, 4'h1, 10'h000, 1'b0);
    chk("thr midrst count", 32'(t_cnt), 32'd0);
    for (int k = 0; k < 3; k++) begin
      q();
      chk($sformatf("thr requal c%0d", k), 32'(t_block), 32'h0);
    end
    q();
    chk("thr requal block", 32'(t_block), 32'h1);

    // THRESH=4: clear on the qualifying cycle suppresses entry
    nq();
    q(); q(); q();
    step(1'b1, 10'h3FD, 4'h1, 10'h000, 1'b1);
    chk("thr clr block", 32'(t_block), 32'h0);
    chk("thr clr pulse", 32'(t_pulse), 32'h0);
    chk("thr clr count", 32'(t_cnt), 32'd1);
    q();
    chk("thr clr restart", 32'(t_block), 32'h0);

    // STICKY=1: held through cond loss, released by clear
    step(1'b0, 10'h3FF, 4'h0, 10'h000, 1'b0);
    q();
    chk("sticky entry", 32'(s_block), 32'h1);
    for (int k = 0; k < 3; k++) begin
      nq();
      chk($sformatf("sticky hold c%0d", k), 32'(s_block), 32'h1);
    end
    step(1'b1, 10'h3FF, 4'h0, 10'h000, 1'b1);
    chk("sticky clear block", 32'(s_block), 32'h0);
    chk("sticky clear count", 32'(s_cnt), 32'd1);
    chk("sticky clear snap", 32'(s_sa), 32'h002);

    // CHAN_MODE: all idle never qualifies; channel-only stall qualifies
    step(1'b0, 10'h3FF, 4'h0, 10'h000, 1'b0);
    nq(); nq();
    chk("chan all idle", 32'(c_block), 32'h0);
    step(1'b1, 10'h3FE, 4'h0, 10'h001, 1'b0);
    chk("chan block", 32'(c_block), 32'h1);
    chk("chan snap_chan", 32'(c_sc), 32'h001);
    chk("chan snap_axis", 32'(c_sa), 32'h000);
    chk("chan count", 32'(c_cnt), 32'd1);
    chk("chan off build", 32'(a_block), 32'h0);

    // CNT_W=2: count saturates at 3 across five entries
    step(1'b0, 10'h3FF, 4'h0, 10'h000, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      q();
      if (n_pulse) pulses++;
      chk($sformatf("sat count e%0d", k), 32'(n_cnt), (k > 3) ? 32'd3 : 32'(k));
      nq();
      chk($sformatf("sat exit e%0d", k), 32'({n_block, n_pulse}), 32'h0);
    end
    chk("sat pulses", 32'(pulses), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
